// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared state encoding, default sizes and lane-arithmetic helper for the
// LSU memory-port arbiter.
package lsu_mem_arbiter_pkg;

  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    MC_IDLE       = 2'd0,
    MC_READ_WAIT  = 2'd1,
    MC_WRITE_WAIT = 2'd2,
    MC_RELEASE    = 2'd3
  } mc_state_e;

  // Lane that follows `lane` in round-robin order.
  function automatic int next_lane(input int lane, input int num_lanes);
    return (lane + 32'sd1) % num_lanes;
  endfunction

endpackage

// File: rtl/lsu_mem_arbiter_if.sv
// LSU-side and memory-side buses of the arbiter. The arbiter takes the slave
// view; the LSU array / memory environment takes the master view.
interface lsu_mem_arbiter_if
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [NUM_LANES-1:0]            lsu_read_valid;
  logic [NUM_LANES-1:0]            lsu_write_valid;
  logic [NUM_LANES*ADDR_WIDTH-1:0] lsu_addr;
  logic [NUM_LANES*DATA_WIDTH-1:0] lsu_write_data;
  logic [NUM_LANES-1:0]            lsu_read_ack;
  logic [NUM_LANES-1:0]            lsu_write_ack;
  logic [NUM_LANES*DATA_WIDTH-1:0] lsu_read_data;

  logic                            mem_read_valid;
  logic                            mem_write_valid;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_write_data;
  logic                            mem_read_ready;
  logic                            mem_write_ready;
  logic [DATA_WIDTH-1:0]           mem_read_data;

  modport slave (
    input  lsu_read_valid, lsu_write_valid, lsu_addr, lsu_write_data,
    input  mem_read_ready, mem_write_ready, mem_read_data,
    output lsu_read_ack, lsu_write_ack, lsu_read_data,
    output mem_read_valid, mem_write_valid, mem_addr, mem_write_data
  );

  modport master (
    output lsu_read_valid, lsu_write_valid, lsu_addr, lsu_write_data,
    output mem_read_ready, mem_write_ready, mem_read_data,
    input  lsu_read_ack, lsu_write_ack, lsu_read_data,
    input  mem_read_valid, mem_write_valid, mem_addr, mem_write_data
  );

endinterface

// File: rtl/lsu_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after rr_ptr,
// wrapping around the lane count.
module rr_arbiter #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    rr_ptr,
  output logic [LANE_W-1:0]    grant,
  output logic                 any_req
);

  logic found_s;
  int   idx_s;

  // Scan lanes starting at the pointer; the first hit wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx_s = (int'(rr_ptr) + k) % NUM_LANES;
      if (!found_s && req[idx_s]) begin
        grant   = LANE_W'(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port among the per-lane LSUs of a SIMD core:
// round-robin grant, request forwarding, per-lane ack and read-data return.
module lsu_mem_arbiter
  import lsu_mem_arbiter_pkg::*;
#(
  parameter int  NUM_LANES  = DEF_NUM_LANES,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int LANE_W     = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  lsu_mem_arbiter_if.slave     bus,
  output logic                 busy,
  output logic [LANE_W-1:0]    grant_lane
);

  mc_state_e                       state_r, state_s;
  logic [LANE_W-1:0]               rr_ptr_r, rr_ptr_s;
  logic [LANE_W-1:0]               grant_r, grant_s;
  logic [LANE_W-1:0]               pick_s;
  logic                            any_req_s;
  logic [NUM_LANES-1:0]            req_s;
  logic [NUM_LANES-1:0]            rack_r, rack_s;
  logic [NUM_LANES-1:0]            wack_r, wack_s;
  logic                            mem_rv_r, mem_rv_s;
  logic                            mem_wv_r, mem_wv_s;
  logic                            busy_r, busy_s;
  logic [ADDR_WIDTH-1:0]           addr_r, addr_s;
  logic [DATA_WIDTH-1:0]           wdata_r, wdata_s;
  logic [NUM_LANES*DATA_WIDTH-1:0] rdata_r, rdata_s;

  assign req_s = bus.lsu_read_valid | bus.lsu_write_valid;

  rr_arbiter #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_rr_arbiter (
    .req     (req_s),
    .rr_ptr  (rr_ptr_r),
    .grant   (pick_s),
    .any_req (any_req_s)
  );

  // Next-state and next-output logic; every output is the registered image.
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    grant_s  = grant_r;
    mem_rv_s = mem_rv_r;
    mem_wv_s = mem_wv_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    rack_s   = '0;
    wack_s   = '0;
    rdata_s  = rdata_r;

    case (state_r)
      MC_IDLE: begin
        if (any_req_s) begin
          grant_s = pick_s;
          addr_s  = bus.lsu_addr[pick_s*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_s = bus.lsu_write_data[pick_s*DATA_WIDTH +: DATA_WIDTH];
          // A lane presenting both requests gets its read served first.
          if (bus.lsu_read_valid[pick_s]) begin
            mem_rv_s = 1'b1;
            state_s  = MC_READ_WAIT;
          end else begin
            mem_wv_s = 1'b1;
            state_s  = MC_WRITE_WAIT;
          end
        end else begin
          state_s = MC_IDLE;
        end
      end
      MC_READ_WAIT: begin
        if (bus.mem_read_ready) begin
          mem_rv_s                                    = 1'b0;
          rack_s[grant_r]                             = 1'b1;
          rdata_s[grant_r*DATA_WIDTH +: DATA_WIDTH]   = bus.mem_read_data;
          state_s                                     = MC_RELEASE;
        end else begin
          state_s = MC_READ_WAIT;
        end
      end
      MC_WRITE_WAIT: begin
        if (bus.mem_write_ready) begin
          mem_wv_s        = 1'b0;
          wack_s[grant_r] = 1'b1;
          state_s         = MC_RELEASE;
        end else begin
          state_s = MC_WRITE_WAIT;
        end
      end
      MC_RELEASE: begin
        rr_ptr_s = LANE_W'(next_lane(int'(grant_r), NUM_LANES));
        state_s  = MC_IDLE;
      end
      default: begin
        mem_rv_s = 1'b0;
        mem_wv_s = 1'b0;
        state_s  = MC_IDLE;
      end
    endcase

    busy_s = (state_s != MC_IDLE);
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= MC_IDLE;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      mem_rv_r <= 1'b0;
      mem_wv_r <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rack_r   <= '0;
      wack_r   <= '0;
      rdata_r  <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
      grant_r  <= grant_s;
      mem_rv_r <= mem_rv_s;
      mem_wv_r <= mem_wv_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      rack_r   <= rack_s;
      wack_r   <= wack_s;
      rdata_r  <= rdata_s;
      busy_r   <= busy_s;
    end
  end

  assign bus.mem_read_valid  = mem_rv_r;
  assign bus.mem_write_valid = mem_wv_r;
  assign bus.mem_addr        = addr_r;
  assign bus.mem_write_data  = wdata_r;
  assign bus.lsu_read_ack    = rack_r;
  assign bus.lsu_write_ack   = wack_r;
  assign bus.lsu_read_data   = rdata_r;
  assign busy                = busy_r;
  assign grant_lane          = grant_r;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed and randomized checks of the LSU memory arbiter against a
// transaction-level model (round-robin pick, memory array, per-lane data).
module tb_lsu_mem_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 7;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [LW-1:0] grant_lane;

  lsu_mem_arbiter_if #(.NUM_LANES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lsu_mem_arbiter #(.NUM_LANES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .grant_lane (grant_lane)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  int            rr_m;
  logic [DW-1:0] mem_m   [0:(1<<AW)-1];
  logic [DW-1:0] rdata_m [0:N-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requesting lane at or after ptr, wrapping; -1 when none.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_lane(input int l, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.lsu_read_valid[l]          = rd;
    bus.lsu_write_valid[l]         = wr;
    bus.lsu_addr[l*AW +: AW]       = a;
    bus.lsu_write_data[l*DW +: DW] = d;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_rack"}, DW'(bus.lsu_read_ack), '0);
    chk({tag, "_wack"}, DW'(bus.lsu_write_ack), '0);
    chk({tag, "_mrv"}, DW'(bus.mem_read_valid), '0);
    chk({tag, "_mwv"}, DW'(bus.mem_write_valid), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
  endtask

  task automatic check_rdata(input string tag);
    for (int l = 0; l < N; l++) chk(tag, bus.lsu_read_data[l*DW +: DW], rdata_m[l]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.lsu_read_valid  = '0;
    bus.lsu_write_valid = '0;
    bus.lsu_addr        = '0;
    bus.lsu_write_data  = '0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data   = '0;
    tick();
    tick();
    rr_m = 0;
    for (int l = 0; l < N; l++) rdata_m[l] = '0;
    check_quiet("rst");
    chk("rst_grant", DW'(grant_lane), '0);
    chk("rst_addr", DW'(bus.mem_addr), '0);
    chk("rst_wdata", bus.mem_write_data, '0);
    check_rdata("rst_rdata");
    rst = 1'b1;
    tick();
  endtask

  // Serve one grant with `wt` memory wait cycles; reports lane and kind.
  task automatic serve(input int wt, output int lane, output logic was_rd);
    logic [N-1:0]  req;
    int            exp;
    logic          is_rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          seen;
    seen = 1'b0;
    exp = -1; is_rd = 1'b0; a = '0; d = '0;
    lane = -1; was_rd = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      req   = bus.lsu_read_valid | bus.lsu_write_valid;
      exp   = model_pick(req, rr_m);
      is_rd = (exp >= 0) ? bus.lsu_read_valid[exp] : 1'b0;
      a     = (exp >= 0) ? bus.lsu_addr[exp*AW +: AW] : '0;
      d     = (exp >= 0) ? bus.lsu_write_data[exp*DW +: DW] : '0;
      tick();
      seen = bus.mem_read_valid | bus.mem_write_valid;
    end
    if (!seen || exp < 0) begin
      total++;
      bad++;
      $error("FAIL grant_timeout observed=no_grant expected=grant");
      return;
    end
    chk("grant_lane", DW'(grant_lane), DW'(exp));
    chk("grant_mrv", DW'(bus.mem_read_valid), DW'(is_rd));
    chk("grant_mwv", DW'(bus.mem_write_valid), DW'(!is_rd));
    chk("grant_addr", DW'(bus.mem_addr), DW'(a));
    if (!is_rd) chk("grant_wdata", bus.mem_write_data, d);
    chk("grant_busy", DW'(busy), DW'(1));
    // Post-grant bus changes must not reach memory.
    bus.lsu_addr[exp*AW +: AW]       = AW'($urandom);
    bus.lsu_write_data[exp*DW +: DW] = {$urandom, $urandom};
    for (int w = 0; w < wt; w++) begin
      tick();
      chk("wait_addr", DW'(bus.mem_addr), DW'(a));
      chk("wait_valid", DW'(bus.mem_read_valid | bus.mem_write_valid), DW'(1));
      chk("wait_ack", DW'(bus.lsu_read_ack | bus.lsu_write_ack), '0);
    end
    if (is_rd) begin
      bus.mem_read_data  = mem_m[a];
      bus.mem_read_ready = 1'b1;
    end else begin
      bus.mem_write_ready = 1'b1;
    end
    tick();
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data   = {$urandom, $urandom};
    if (is_rd) rdata_m[exp] = mem_m[a];
    else mem_m[a] = d;
    chk("ack_rd", DW'(bus.lsu_read_ack), is_rd ? DW'(1) << exp : '0);
    chk("ack_wr", DW'(bus.lsu_write_ack), is_rd ? '0 : DW'(1) << exp);
    chk("ack_mvalid", DW'(bus.mem_read_valid | bus.mem_write_valid), '0);
    check_rdata("ack_rdata");
    if (is_rd) bus.lsu_read_valid[exp] = 1'b0;
    else bus.lsu_write_valid[exp] = 1'b0;
    rr_m = (exp + 1) % N;
    tick();
    check_quiet("rel");
    lane   = exp;
    was_rd = is_rd;
  endtask

  initial begin
    int   lane;
    logic rd;
    int   pending;
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = {$urandom, $urandom};

    do_reset();

    // Single read on lane 2 with two wait cycles.
    mem_m[7'h15] = 64'hDEADBEEF;
    set_lane(2, 1'b1, 1'b0, 7'h15, '0);
    serve(2, lane, rd);
    chk("single_lane", DW'(lane), DW'(2));
    chk("single_data", bus.lsu_read_data[2*DW +: DW], 64'hDEADBEEF);

    // Four simultaneous writes, zero-wait memory.
    do_reset();
    for (int l = 0; l < N; l++) set_lane(l, 1'b0, 1'b1, AW'(l), DW'(l + 16));
    for (int k = 0; k < N; k++) begin
      serve(0, lane, rd);
      chk("cont_order", DW'(lane), DW'(k));
      chk("cont_mem", mem_m[k], DW'(k + 16));
    end

    // Pointer at 3 after serving lane 2; lanes 1 and 3 contend.
    do_reset();
    set_lane(2, 1'b1, 1'b0, 7'h01, '0);
    serve(0, lane, rd);
    set_lane(1, 1'b1, 1'b0, 7'h22, '0);
    set_lane(3, 1'b1, 1'b0, 7'h33, '0);
    serve(1, lane, rd);
    chk("wrap_first", DW'(lane), DW'(3));
    serve(0, lane, rd);
    chk("wrap_second", DW'(lane), DW'(1));

    // Both valids on lane 0: read then write.
    set_lane(0, 1'b1, 1'b1, 7'h05, 64'h0123_4567_89AB_CDEF);
    serve(1, lane, rd);
    chk("rw_first_rd", DW'(rd), DW'(1));
    serve(0, lane, rd);
    chk("rw_second_wr", DW'(rd), DW'(0));
    chk("rw_lane", DW'(lane), DW'(0));

    // Reset in the middle of a read.
    set_lane(2, 1'b1, 1'b0, 7'h44, '0);
    tick();
    chk("midrst_pre", DW'(bus.mem_read_valid), DW'(1));
    rst = 1'b0;
    #1;
    check_quiet("midrst");
    chk("midrst_grant", DW'(grant_lane), '0);
    bus.mem_read_ready = 1'b1;
    tick();
    bus.mem_read_ready = 1'b0;
    chk("midrst_noack", DW'(bus.lsu_read_ack), '0);
    bus.lsu_read_valid = '0;
    rr_m = 0;
    for (int l = 0; l < N; l++) rdata_m[l] = '0;
    rst = 1'b1;
    tick();
    set_lane(1, 1'b1, 1'b0, 7'h15, '0);
    serve(0, lane, rd);
    chk("midrst_fresh", DW'(lane), DW'(1));

    // Stray memory readies while idle.
    bus.mem_read_ready  = 1'b1;
    bus.mem_write_ready = 1'b1;
    tick();
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    check_quiet("stray");
    tick();
    check_quiet("stray2");

    // Randomized request mixes.
    for (int r = 0; r < 30; r++) begin
      for (int l = 0; l < N; l++) begin
        set_lane(l, 1'($urandom), 1'($urandom), AW'($urandom), {$urandom, $urandom});
      end
      pending = 0;
      while ((bus.lsu_read_valid | bus.lsu_write_valid) != '0 && pending < 3 * N) begin
        serve($urandom_range(0, 3), lane, rd);
        pending++;
      end
      chk("rand_drained", DW'(bus.lsu_read_valid | bus.lsu_write_valid), '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
